// File: rtl/bcd_counter_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter_display
// Purpose  : DIGITS-wide BCD up/down counter with load, ripple carry/borrow
//            and a wrap pulse, driving a time-multiplexed common-anode
//            7-segment display (one digit per scan slot, registered pins).
// Ports    : clk       - system clock, rising edge
//            rst_n     - synchronous active-low reset
//            en        - count-step strobe (one step per cycle held high)
//            up        - 1: increment, 0: decrement (sampled with en)
//            load      - load load_val (priority over en)
//            load_val  - BCD load value, digit k = [4k+3:4k]
//            count     - current BCD count, same packing
//            wrap      - one-cycle pulse on full-scale roll-over
//            seg       - segments, seg[0]=a .. seg[6]=g
//            an        - digit enables, an[k] drives digit k
// Revision : 1.0 - initial release
// ============================================================================
module bcd_counter_display #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int LZ_BLANK       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int                c_IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int                c_SCAN_W   = $clog2(SCAN_DIV);
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(DIGITS - 1);
    localparam logic [c_SCAN_W-1:0] c_LAST_SCAN = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic              c_SEG_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic              c_AN_INV   = (AN_ACTIVE_LOW != 0);
    localparam logic              c_LZ       = (LZ_BLANK != 0);
    localparam logic [6:0]        c_SEG_OFF  = {7{c_SEG_INV}};
    localparam logic [DIGITS-1:0] c_AN_OFF   = {DIGITS{c_AN_INV}};

    // Lit-segment pattern (bit 0 = a .. bit 6 = g), active-high.
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'h3F;
            4'd1:    f_decode = 7'h06;
            4'd2:    f_decode = 7'h5B;
            4'd3:    f_decode = 7'h4F;
            4'd4:    f_decode = 7'h66;
            4'd5:    f_decode = 7'h6D;
            4'd6:    f_decode = 7'h7D;
            4'd7:    f_decode = 7'h07;
            4'd8:    f_decode = 7'h7F;
            4'd9:    f_decode = 7'h6F;
            default: f_decode = 7'h00;
        endcase
    endfunction

    logic [4*DIGITS-1:0] r_count;
    logic                r_wrap;
    logic [c_SCAN_W-1:0] r_scan;
    logic [c_IDX_W-1:0]  r_idx;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_an;

    logic [4*DIGITS-1:0] w_load_clean;
    logic [4*DIGITS-1:0] w_step_count;
    logic                w_carry;
    logic [DIGITS-1:0]   w_upper_zero;
    logic                w_zero_run;
    logic [DIGITS-1:0]   w_an_lit;
    logic [3:0]          w_cur_digit;
    logic                w_blank;
    logic [6:0]          w_seg_lit;

    // Non-BCD load digits are forced to 0 so the counter never holds an
    // illegal digit.
    for (genvar k = 0; k < DIGITS; k++) begin : g_load_clean
        assign w_load_clean[4*k +: 4] = (load_val[4*k +: 4] > 4'd9) ? 4'd0
                                                                    : load_val[4*k +: 4];
    end

    // Ripple carry/borrow: a digit only changes while the carry/borrow from
    // below is still pending. A carry surviving past the top digit is a wrap.
    always_comb begin
        w_step_count = r_count;
        w_carry      = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_carry) begin
                if (up) begin
                    if (r_count[4*k +: 4] == 4'd9) begin
                        w_step_count[4*k +: 4] = 4'd0;
                    end else begin
                        w_step_count[4*k +: 4] = r_count[4*k +: 4] + 4'd1;
                        w_carry                = 1'b0;
                    end
                end else begin
                    if (r_count[4*k +: 4] == 4'd0) begin
                        w_step_count[4*k +: 4] = 4'd9;
                    end else begin
                        w_step_count[4*k +: 4] = r_count[4*k +: 4] - 4'd1;
                        w_carry                = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clean;
            r_wrap  <= 1'b0;
        end else if (en) begin
            r_count <= w_step_count;
            r_wrap  <= w_carry;
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    // w_upper_zero[k]: digit k and every digit above it are zero.
    always_comb begin
        w_upper_zero = '0;
        w_zero_run   = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_zero_run      = w_zero_run && (r_count[4*k +: 4] == 4'd0);
            w_upper_zero[k] = w_zero_run;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_an_sel
        assign w_an_lit[k] = (r_idx == c_IDX_W'(k));
    end

    assign w_cur_digit = r_count[{r_idx, 2'b00} +: 4];
    assign w_blank     = c_LZ && (r_idx != '0) && w_upper_zero[r_idx];
    assign w_seg_lit   = w_blank ? 7'h00 : f_decode(w_cur_digit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_idx  <= '0;
            r_seg  <= c_SEG_OFF;
            r_an   <= c_AN_OFF;
        end else begin
            if (r_scan == c_LAST_SCAN) begin
                r_scan <= '0;
                r_idx  <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
            end else begin
                r_scan <= r_scan + 1'b1;
            end
            r_seg <= w_seg_lit ^ {7{c_SEG_INV}};
            r_an  <= w_an_lit  ^ {DIGITS{c_AN_INV}};
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign seg   = r_seg;
    assign an    = r_an;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_counter_display
// Purpose  : Directed self-checking bench for bcd_counter_display
//            (DIGITS=4, SCAN_DIV=4, active-low pins, leading-zero blanking on
//            the main instance and off on a companion instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_counter_display;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        wrap;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] nb_count;
    logic        nb_wrap;
    logic [6:0]  nb_seg;
    logic [3:0]  nb_an;

    int checks = 0;
    int errors = 0;

    // Active-low segment codes
    localparam logic [6:0] c_S0    = 7'h40;
    localparam logic [6:0] c_S1    = 7'h79;
    localparam logic [6:0] c_S2    = 7'h24;
    localparam logic [6:0] c_S3    = 7'h30;
    localparam logic [6:0] c_S4    = 7'h19;
    localparam logic [6:0] c_S7    = 7'h78;
    localparam logic [6:0] c_BLANK = 7'h7F;

    bcd_counter_display #(
        .DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .LZ_BLANK(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count), .wrap(wrap), .seg(seg), .an(an)
    );

    bcd_counter_display #(
        .DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .LZ_BLANK(0)
    ) dut_nb (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(nb_count), .wrap(nb_wrap), .seg(nb_seg), .an(nb_an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_pins(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
        check({tag, "_an"},  {28'd0, an},  {28'd0, exp_an});
        check({tag, "_seg"}, {25'd0, seg}, {25'd0, exp_seg});
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 16'h0000;

        // 1: reset state, then first decoded digit
        step(2);
        rst_n = 1'b1;
        check("rst_count", {16'd0, count}, 32'h0);
        check("rst_wrap",  {31'd0, wrap},  32'h0);
        check_pins("rst_pins", 4'hF, c_BLANK);
        step(1);
        check_pins("first_digit", 4'b1110, c_S0);

        // 2: carry ripple without wrap
        load = 1'b1; load_val = 16'h0998;
        step(1);
        load = 1'b0; en = 1'b1; up = 1'b1;
        check("load_0998", {16'd0, count}, 32'h0998);
        step(1);
        check("up_0999", {16'd0, count}, 32'h0999);
        check("up_0999_wrap", {31'd0, wrap}, 32'h0);
        step(1);
        en = 1'b0;
        check("up_1000", {16'd0, count}, 32'h1000);
        check("up_1000_wrap", {31'd0, wrap}, 32'h0);

        // 3: up wrap pulse
        load = 1'b1; load_val = 16'h9999;
        step(1);
        load = 1'b0; en = 1'b1; up = 1'b1;
        step(1);
        en = 1'b0;
        check("upwrap_count", {16'd0, count}, 32'h0000);
        check("upwrap_pulse", {31'd0, wrap},  32'h1);
        step(1);
        check("upwrap_end",   {31'd0, wrap},  32'h0);
        check("upwrap_hold",  {16'd0, count}, 32'h0000);

        // 4: down wrap and borrow ripple
        load = 1'b1; load_val = 16'h0000;
        step(1);
        load = 1'b0; en = 1'b1; up = 1'b0;
        step(1);
        en = 1'b0;
        check("dnwrap_count", {16'd0, count}, 32'h9999);
        check("dnwrap_pulse", {31'd0, wrap},  32'h1);
        load = 1'b1; load_val = 16'h1000;
        step(1);
        load = 1'b0; en = 1'b1; up = 1'b0;
        check("load_wrap_clr", {31'd0, wrap}, 32'h0);
        step(1);
        en = 1'b0;
        check("dn_0999", {16'd0, count}, 32'h0999);
        check("dn_0999_wrap", {31'd0, wrap}, 32'h0);

        // 5: illegal digit sanitising, load priority over en
        load = 1'b1; load_val = 16'h0A5F;
        step(1);
        check("load_sanitise", {16'd0, count}, 32'h0050);
        load_val = 16'h9999; en = 1'b1; up = 1'b1;
        step(1);
        check("load_en_9999", {16'd0, count}, 32'h9999);
        check("load_en_nowrap", {31'd0, wrap}, 32'h0);
        load_val = 16'h1234;
        step(1);
        load = 1'b0; en = 1'b0;
        check("load_en_1234", {16'd0, count}, 32'h1234);

        // 6: scan rotation from a fresh reset, load held through release
        rst_n = 1'b0; load = 1'b1; load_val = 16'h1234;
        step(1);
        check("rst2_count", {16'd0, count}, 32'h0);
        rst_n = 1'b1;
        step(1);                              // E1: count becomes 1234, pins from 0000
        load = 1'b0;
        check_pins("scan_e1", 4'b1110, c_S0);
        step(1);                              // E2
        check_pins("scan_d0", 4'b1110, c_S4);
        step(2);                              // E4: still digit 0
        check_pins("scan_d0_end", 4'b1110, c_S4);
        step(1);                              // E5
        check_pins("scan_d1", 4'b1101, c_S3);
        step(4);                              // E9
        check_pins("scan_d2", 4'b1011, c_S2);
        step(4);                              // E13
        check_pins("scan_d3", 4'b0111, c_S1);
        step(4);                              // E17
        check_pins("scan_d0_again", 4'b1110, c_S4);

        // Mid-slot count change: seg follows next cycle, an steady
        load = 1'b1; load_val = 16'h0007;
        step(1);                              // E18
        load = 1'b0;
        check_pins("midslot_old", 4'b1110, c_S4);
        step(1);                              // E19
        check_pins("midslot_new", 4'b1110, c_S7);
        step(2);                              // E21
        check_pins("lz_d1", 4'b1101, c_BLANK);
        check("nolz_d1_seg", {25'd0, nb_seg}, {25'd0, c_S0});
        check("nolz_d1_an",  {28'd0, nb_an},  32'hD);
        step(4);                              // E25
        check_pins("lz_d2", 4'b1011, c_BLANK);
        step(4);                              // E29
        check_pins("lz_d3", 4'b0111, c_BLANK);

        // Reset in the middle of a slot
        rst_n = 1'b0;
        step(1);                              // E30
        rst_n = 1'b1;
        check("midrst_count", {16'd0, count}, 32'h0);
        check("midrst_wrap",  {31'd0, wrap},  32'h0);
        check_pins("midrst_pins", 4'hF, c_BLANK);
        step(1);                              // E31
        check_pins("post_rst_d0", 4'b1110, c_S0);
        step(3);                              // E34
        check_pins("post_rst_d0_end", 4'b1110, c_S0);
        step(1);                              // E35
        check_pins("post_rst_d1", 4'b1101, c_BLANK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
